// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB first through one full-subtractor cell.
// Optional signed-overflow flag is enabled with `define SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_a, cell_b, cell_diff, cell_bout, last;

  assign cell_a    = a_sr_q[0];
  assign cell_b    = b_sr_q[0];
  assign cell_diff = cell_a ^ cell_b ^ br_q;
  assign cell_bout = (~cell_a & cell_b) | (~cell_a & br_q) | (cell_b & br_q);
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every _d starts as its _q (done as 0) so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        diff_d = {cell_diff, diff_q[WIDTH-1:1]};
        br_d   = cell_bout;
        if (last) begin
          // Counter parks at WIDTH-1 instead of wrapping.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = cell_bout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;

  // The final cell sees the operand MSBs, so no separate capture flops are needed.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      ovf_d = 1'b0;
    end else if (state_q == SHIFT && last) begin
      ovf_d = (cell_a != cell_b) && (cell_diff != cell_a);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout, ovf;
  logic [7:0] diff;

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Runs one operation; operands are scrambled after the accept edge.
  // Returns with the bench at the falling edge of the done cycle.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       output int edges, output int busy_cycles,
                       output logic [7:0] diff_at_accept, output bit timeout);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    edges = 1; busy_cycles = 0; timeout = 1'b0;
    @(negedge clk);
    diff_at_accept = diff;
    start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
    while (!done) begin
      if (busy) busy_cycles++;
      if (edges > 40) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e, bc; logic [7:0] d0; bit to;
    do_op(8'h35, 8'h12, 1'b0, e, bc, d0, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL basic_timeout: no done within bound"); end
    n_cmp++;
    if (e !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d edges, want 9", e); end
    n_cmp++;
    if (bc !== 8) begin n_bad++; $display("FAIL basic_busy: got %0d cycles, want 8", bc); end
    n_cmp++;
    if (d0 !== 8'h00) begin n_bad++; $display("FAIL basic_clear: diff after accept %h, want 00", d0); end
    n_cmp++;
    if ({bout, diff} !== 9'h023) begin
      n_bad++; $display("FAIL basic_result: got bout=%b diff=%h, want bout=0 diff=23", bout, diff);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || diff !== 8'h23) begin
      n_bad++; $display("FAIL basic_pulse: got done=%b diff=%h after done cycle, want done=0 diff=23", done, diff);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic bin; logic [8:0] exp; } vec_t;

  task automatic test_arith();
    vec_t v[5];
    int e, bc; logic [7:0] d0; bit to;
    v[0] = '{8'h00, 8'h01, 1'b0, 9'h1FF};
    v[1] = '{8'h10, 8'h0F, 1'b1, 9'h000};
    v[2] = '{8'h00, 8'h00, 1'b1, 9'h1FF};
    v[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    v[4] = '{8'hA5, 8'h5A, 1'b0, 9'h04B};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].a, v[i].b, v[i].bin, e, bc, d0, to);
      n_cmp++;
      if (to || {bout, diff} !== v[i].exp || ovf !== 1'b0 && v[i].a == 8'hFF) begin
        n_bad++;
        $display("FAIL arith_%0d: a=%h b=%h bin=%b got bout=%b diff=%h, want {bout,diff}=%h",
                 i, v[i].a, v[i].b, v[i].bin, bout, diff, v[i].exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [8:0] res = '0;
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hF0; b = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin dones++; res = {bout, diff}; end
    end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL ignore_count: got %0d done pulses, want 1", dones); end
    n_cmp++;
    if (res !== 9'h023) begin n_bad++; $display("FAIL ignore_result: got %h, want 023", res); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle: busy=%b, want 0", busy); end
  endtask

  task automatic test_abort();
    int e, bc; logic [7:0] d0; bit to;
    int dones = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || diff !== 8'hF0) begin
      n_bad++; $display("FAIL abort_partial: got busy=%b diff=%h, want busy=1 diff=F0", busy, diff);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      n_bad++; $display("FAIL abort_clear: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                        busy, done, diff, bout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL abort_nodone: activity in %0d cycles, want 0", dones); end
    do_op(8'h35, 8'h12, 1'b0, e, bc, d0, to);
    n_cmp++;
    if (to || e !== 9 || {bout, diff} !== 9'h023) begin
      n_bad++; $display("FAIL abort_recover: got edges=%0d bout=%b diff=%h, want 9/0/23", e, bout, diff);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [8:0] r1 = '0, r2 = '0;
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin
          t1 = i; r1 = {bout, diff};
          a = 8'h10; b = 8'h0F; bin = 1'b1;
        end else if (t2 < 0) begin
          t2 = i; r2 = {bout, diff};
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t1 < 0 || t2 < 0 || t2 - t1 !== 10) begin
      n_bad++; $display("FAIL b2b_period: done at %0d and %0d, want spacing 10", t1, t2);
    end
    n_cmp++;
    if (r1 !== 9'h023 || r2 !== 9'h000) begin
      n_bad++; $display("FAIL b2b_results: got %h then %h, want 023 then 000", r1, r2);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_ovf();
    int e, bc; logic [7:0] d0; bit to;
`ifdef SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, e, bc, d0, to);
    n_cmp++;
    if (to || diff !== 8'h7F || ovf !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: got diff=%h ovf=%b, want 7F/1", diff, ovf);
    end
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got ovf=%b after start, want 0", ovf); end
    repeat (12) @(negedge clk);
    do_op(8'h05, 8'h03, 1'b0, e, bc, d0, to);
    n_cmp++;
    if (to || diff !== 8'h02 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_none: got diff=%h ovf=%b, want 02/0", diff, ovf);
    end
`else
    do_op(8'h80, 8'h01, 1'b0, e, bc, d0, to);
    n_cmp++;
    if (to || diff !== 8'h7F || ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_tied: got diff=%h ovf=%b, want 7F/0", diff, ovf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
